// File: rtl/burst_rr_arbiter_if.sv
// Bundle of requester-side and downstream-side streaming signals for burst_rr_arbiter.
// The arbiter attaches through the slave modport; the traffic source/sink attaches through master.
interface burst_rr_arbiter_if #(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned LEN_WIDTH      = 3
);
  localparam int unsigned ID_WIDTH = $clog2(NUM_REQUESTERS);

  logic [NUM_REQUESTERS-1:0]            req_valid;
  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQUESTERS*LEN_WIDTH-1:0]  req_len;
  logic [NUM_REQUESTERS-1:0]            req_ready;
  logic                                 out_valid;
  logic [DATA_WIDTH-1:0]                out_data;
  logic                                 out_last;
  logic [ID_WIDTH-1:0]                  out_id;
  logic                                 out_ready;

  modport slave (
    input  req_valid, req_data, req_len, out_ready,
    output req_ready, out_valid, out_data, out_last, out_id
  );

  modport master (
    output req_valid, req_data, req_len, out_ready,
    input  req_ready, out_valid, out_data, out_last, out_id
  );
endinterface

// File: rtl/burst_rr_arbiter.sv
// Round-robin arbiter sharing one downstream stream among NUM_REQUESTERS sources;
// a grant is held for a whole burst and the priority pointer moves only after its last beat.
module burst_rr_arbiter #(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned LEN_WIDTH      = 3
) (
  input  logic                clk,
  input  logic                reset,
  burst_rr_arbiter_if.slave   bus
);
  localparam int unsigned ID_WIDTH = $clog2(NUM_REQUESTERS);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                    state;
  logic [LEN_WIDTH-1:0]      beat_cnt;
  logic [ID_WIDTH-1:0]       grant_idx;
  logic [NUM_REQUESTERS-1:0] grant_oh;
  logic [NUM_REQUESTERS-1:0] last_grant;

  logic [DATA_WIDTH-1:0]     data_arr [NUM_REQUESTERS];
  logic [LEN_WIDTH-1:0]      len_arr  [NUM_REQUESTERS];
  logic [ID_WIDTH-1:0]       last_idx;
  logic [ID_WIDTH-1:0]       cand;
  logic [ID_WIDTH-1:0]       winner;
  logic [NUM_REQUESTERS-1:0] winner_oh;
  logic                      found;
  logic                      beat;

  // Per-requester views of the flattened payload and length buses
  for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_unpack
    assign data_arr[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign len_arr[gi]  = bus.req_len[gi*LEN_WIDTH +: LEN_WIDTH];
  end

  // Search upward from the requester after the last completed grant, wrapping
  always_comb begin
    last_idx = '0;
    cand     = '0;
    winner   = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (last_grant[i]) last_idx = ID_WIDTH'(i);
    end
    for (int unsigned k = 1; k <= NUM_REQUESTERS; k++) begin
      cand = ID_WIDTH'((32'(last_idx) + k) % NUM_REQUESTERS);
      if (!found && bus.req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign winner_oh = NUM_REQUESTERS'(1) << winner;

  // Downstream handshake passes straight through from the granted requester
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    bus.req_ready = '0;
    if (state == BURST) begin
      bus.out_valid = bus.req_valid[grant_idx];
      bus.out_data  = data_arr[grant_idx];
      bus.out_last  = bus.req_valid[grant_idx] && (beat_cnt == '0);
      bus.req_ready = grant_oh & {NUM_REQUESTERS{bus.out_ready}};
    end
  end

  assign beat       = bus.out_valid && bus.out_ready;
  assign bus.out_id = grant_idx;

  // Grant index doubles as out_id, so it is cleared whenever the arbiter returns to IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      grant_idx  <= '0;
      grant_oh   <= '0;
      last_grant <= NUM_REQUESTERS'(1) << (NUM_REQUESTERS - 1);
    end else if (state == IDLE) begin
      if (found) begin
        grant_idx <= winner;
        grant_oh  <= winner_oh;
        beat_cnt  <= len_arr[winner];
        state     <= BURST;
      end
    end else if (beat) begin
      if (beat_cnt == '0) begin
        last_grant <= grant_oh;
        grant_oh   <= '0;
        grant_idx  <= '0;
        state      <= IDLE;
      end else begin
        beat_cnt <= beat_cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Randomized bench for burst_rr_arbiter: per-requester burst scoreboards plus a
// transaction-level round-robin model checked by an independent negedge monitor.
module tb_burst_rr_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 3;
  localparam int unsigned IW = $clog2(NR);
  localparam int NUM_BURSTS = 160;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  burst_rr_arbiter_if #(.NUM_REQUESTERS(NR), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  burst_rr_arbiter #(.NUM_REQUESTERS(NR), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q [NR][$];
  logic [DW-1:0] drv_q [NR][$];
  int            sent  [NR];
  logic [NR-1:0] acc;
  int            bursts_left = NUM_BURSTS;
  int            checks = 0;
  int            errors = 0;

  bit    mon_en = 1'b0;
  bit    m_busy = 1'b0;
  int    m_g    = 0;
  int    m_last = NR - 1;
  beat_t m_b;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Round-robin rule: first valid requester after the last served one, wrapping
  function automatic int rr_pick(int last, logic [NR-1:0] v);
    for (int k = 1; k <= int'(NR); k++) begin
      int c;
      c = (last + k) % int'(NR);
      if (v[IW'(c)]) return c;
    end
    return 0;
  endfunction

  function automatic bit drained();
    bit d;
    d = (bursts_left == 0) && !m_busy;
    for (int i = 0; i < int'(NR); i++) begin
      if (drv_q[i].size() != 0 || exp_q[i].size() != 0) d = 1'b0;
    end
    return d;
  endfunction

  // Monitor: samples settled outputs just before the edge that would accept a beat
  always @(negedge clk) begin
    if (mon_en) begin
      if (!m_busy) begin
        chk("idle_outputs", 64'({bus.out_valid, bus.out_last, bus.req_ready, bus.out_id, bus.out_data}), 64'(0));
        if (|bus.req_valid) begin
          m_g    = rr_pick(m_last, bus.req_valid);
          m_busy = 1'b1;
        end
      end else begin
        chk("out_id", 64'(bus.out_id), 64'(m_g));
        chk("out_valid", 64'(bus.out_valid), 64'(bus.req_valid[IW'(m_g)]));
        chk("req_ready", 64'(bus.req_ready), bus.out_ready ? (64'(1) << m_g) : 64'(0));
        if (!bus.out_valid) begin
          chk("out_last_gap", 64'(bus.out_last), 64'(0));
        end else if (exp_q[m_g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: id %0d data %0h with no burst outstanding", m_g, bus.out_data);
        end else begin
          m_b = exp_q[m_g][0];
          chk("out_data", 64'(bus.out_data), 64'(m_b.data));
          chk("out_last", 64'(bus.out_last), 64'(m_b.last));
          if (bus.out_ready) begin
            void'(exp_q[m_g].pop_front());
            if (m_b.last) begin
              m_busy = 1'b0;
              m_last = m_g;
            end
          end
        end
      end
    end
  end

  // One cycle of random traffic: accept bookkeeping, new bursts, valid drops, length noise
  task automatic drive_cycle();
    int            len;
    logic [DW-1:0] d;
    @(negedge clk);
    acc = bus.req_ready & bus.req_valid;
    @(posedge clk);
    #1;
    bus.out_ready = ($urandom_range(0, 9) < 7);
    for (int i = 0; i < int'(NR); i++) begin
      if (acc[i]) begin
        void'(drv_q[i].pop_front());
        sent[i]++;
      end
      if (drv_q[i].size() == 0 && bursts_left > 0 && $urandom_range(0, 3) == 0) begin
        len = ($urandom_range(0, 3) == 0) ? int'(2**LW - 1) : int'($urandom_range(0, 2**LW - 1));
        for (int b = 0; b <= len; b++) begin
          d = $urandom;
          drv_q[i].push_back(d);
          exp_q[i].push_back('{data: d, last: (b == len)});
        end
        bus.req_len[i*LW +: LW] = LW'(len);
        sent[i] = 0;
        bursts_left--;
      end
      if (drv_q[i].size() != 0) begin
        bus.req_valid[i]        = ($urandom_range(0, 5) != 0);
        bus.req_data[i*DW +: DW] = drv_q[i][0];
        if (sent[i] > 0) bus.req_len[i*LW +: LW] = LW'($urandom);
      end else begin
        bus.req_valid[i]        = 1'b0;
        bus.req_data[i*DW +: DW] = $urandom;
      end
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_len   = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < int'(NR); i++) sent[i] = 0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("reset_idle", 64'({bus.out_valid, bus.out_last, bus.req_ready, bus.out_id, bus.out_data}), 64'(0));
    end

    mon_en = 1'b1;
    for (int c = 0; c < 30000; c++) begin
      drive_cycle();
      if (drained()) break;
    end
    chk("traffic_drained", 64'(drained()), 64'(1));
    mon_en = 1'b0;

    // Reset during beat 2 of a 4-beat burst from requester 3
    bus.out_ready             = 1'b1;
    bus.req_valid             = 4'b1000;
    bus.req_len[3*LW +: LW]   = LW'(3);
    bus.req_data[3*DW +: DW]  = 32'hD000_0000;
    @(posedge clk);
    #1;
    chk("rst_grant_id", 64'(bus.out_id), 64'(3));
    chk("rst_beat1_valid", 64'(bus.out_valid), 64'(1));
    @(posedge clk);
    #1;
    bus.req_data[3*DW +: DW] = 32'hD000_0001;
    #1;
    chk("rst_beat2_data", 64'(bus.out_data), 64'(32'hD000_0001));
    chk("rst_beat2_last", 64'(bus.out_last), 64'(0));
    chk("rst_beat2_ready", 64'(bus.req_ready), 64'(4'b1000));
    reset         = 1'b1;
    bus.req_valid = 4'b1001;
    bus.req_len   = '0;
    @(posedge clk);
    #1;
    chk("rst_mid_burst_outputs", 64'({bus.out_valid, bus.out_last, bus.req_ready, bus.out_id, bus.out_data}), 64'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_grant", 64'(bus.out_id), 64'(0));
    chk("post_reset_valid", 64'(bus.out_valid), 64'(1));
    chk("post_reset_ready", 64'(bus.req_ready), 64'(4'b0001));
    chk("post_reset_last", 64'(bus.out_last), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/burst_rr_arbiter.md
Name: burst_rr_arbiter

Overview:
- Shares one downstream streaming port between NUM_REQUESTERS sources using round-robin arbitration.
- A grant is locked for a whole multi-beat burst and released after the last beat.
- Priority advances only after a completed burst.
- Sits between per-core request queues and a shared memory/interconnect port.

Parameters:
NUM_REQUESTERS, 4, number of requesting ports (>=2)
DATA_WIDTH, 32, payload width per beat
LEN_WIDTH, 3, width of burst length field; burst = len+1 beats (1..2^LEN_WIDTH)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQUESTERS  requester i has a beat available
req_data  input  NUM_REQUESTERS*DATA_WIDTH  beat payload, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_len  input  NUM_REQUESTERS*LEN_WIDTH  burst length minus one; valid with requester's first beat
req_ready  output  NUM_REQUESTERS  beat of requester i accepted this cycle
out_valid  output  1  downstream beat valid
out_data  output  DATA_WIDTH  downstream payload
out_last  output  1  final beat of current burst
out_id  output  $clog2(NUM_REQUESTERS)  index of granted requester
out_ready  input  1  downstream accepts beat

Behaviour:
- Clocking: one clock (clk); reset is synchronous, active-high.
- Reset values:
  - State IDLE; beat counter 0; grant 0.
  - Priority pointer last_grant = one-hot bit NUM_REQUESTERS-1, so requester 0 has highest priority first.
  - All outputs 0: req_ready, out_valid, out_last, out_id, out_data.
- State IDLE:
  - All outputs 0.
  - If any req_valid: winner = first set bit searching upward from (last_grant index + 1), wrapping.
  - Register grant_oh/out_id for the winner; load beat counter with req_len[winner]; next state BURST.
  - If no req_valid: stay IDLE.
  - Arbitration latency: 1 cycle from request to first out_valid.
- State BURST (granted index g):
  - Combinational outputs: out_valid = req_valid[g]; out_data = req_data[g]; req_ready[g] = out_ready; req_ready of all other requesters = 0.
  - Beat = out_valid && out_ready.
  - Each beat decrements the counter.
  - out_last = out_valid && (counter == 0).
  - Beat with counter == 0: last_grant <= grant_oh; next state IDLE.
  - One idle bubble cycle separates bursts; no back-to-back grant.
- Boundary conditions:
  - req_len is sampled only at grant. Changes during a burst are ignored.
  - Requester drops req_valid mid-burst: out_valid drops; grant held indefinitely; no timeout; counter unchanged.
  - Other requesters' req_valid during a burst: no effect; their req_ready stays 0.
  - out_ready low: counter holds; out_valid/out_data follow the granted requester; out_last may be held high.
  - len = 0: single beat with out_last=1.
  - len = 2^LEN_WIDTH-1: counter wraps no further; exactly 2^LEN_WIDTH beats.
  - Only one requester active: it is re-granted every burst, separated by one bubble.
  - Reset mid-burst: next cycle IDLE with all outputs 0 and pointer restored; partial burst is abandoned (no out_last).
- Fairness: with all requesters continuously valid, grant order is 0,1,...,N-1,0,... independent of burst lengths.

Test Plan:
- Reset held 3 cycles then released, req_valid=0 -> out_valid, req_ready, out_last, out_id all 0 for 5 cycles; stays IDLE.
- req_valid=4'b1111, all req_len=1, out_ready=1 -> bursts on out_id 0,1,2,3,0. Each burst is 2 beats with out_last on the 2nd. One bubble cycle between bursts (3 cycles per burst). Each req_ready pulses only for the granted id.
- req_valid=4'b0101, req_len=0 -> out_id sequence 0,2,0,2, each 1 beat with out_last=1. req_ready[1] and req_ready[3] never assert.
- Requester 1 only, req_len=3, out_ready toggling 1,0,1,0…; req_valid[3] raised mid-burst -> exactly 4 beats transferred, out_last only on 4th accepted beat, req_ready[3]=0 throughout. Requester 3 granted after the bubble.
- Requester 2 granted with req_len=2; drops req_valid for 4 cycles after beat 1 while requester 0 requests -> out_valid=0 during gap, out_id stays 2, requester 0 not served. Burst completes with 3 beats, then requester 0 is granted.
- Reset asserted during beat 2 of a 4-beat burst from requester 3 -> next cycle all outputs 0. With req_valid=4'b1001 after reset, first grant is requester 0, not 3.
